rr_pipe_arbiter: RTL
====================

# rr_pipe_arbiter

Round-robin arbiter that shares one fixed-latency `delay` pipeline instance between N requesters. It grants at most one request per cycle and drives the shared pipeline input. A matching tag pipeline carries the requester ID alongside the data, so each result returns to its originator as a one-cycle response pulse. It sits between the requesting datapath blocks and a single `delay` instance whose CLK_DEL equals LAT.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width; must equal the W of the shared delay instance
- LAT, 2, latency of the shared delay instance; must equal its CLK_DEL (>=1)
- IDW, $clog2(N), requester ID width (derived)
- CW, $clog2(LAT+3), in-flight counter width (derived)

Ports:
- clk  in  1  posedge clock, single clock domain
- rst  in  1  synchronous reset, active-high; the same net also resets the shared delay instance
- req  in  N  request per requester; level, held until granted
- req_data  in  N*W  requester i data is bits [i*W +: W]
- req_mask  in  N  1 = requester enabled; masked requests are never granted
- gnt  out  N  one-hot grant, combinational, same cycle as the accepted req
- pipe_valid  out  1  registered; pipe_din holds an accepted request
- pipe_din  out  W  registered; feeds din of the delay instance
- pipe_dout  in  W  dout of the delay instance
- rsp_valid  out  1  registered; one-cycle response pulse
- rsp_id  out  IDW  registered; ID of the requester that owns rsp_data
- rsp_data  out  W  registered; pipe_dout captured for that requester
- in_flight  out  CW  registered count of accepted requests not yet responded

## Operation
- Eligible set: req & req_mask.
- Priority search starts at pointer ptr and wraps modulo N. The first eligible index k gets gnt[k]=1; all other gnt bits are 0. No eligible requester gives gnt=0.
- A request is accepted in a cycle when req[k] & gnt[k] is high. The requester drops or changes req only after seeing gnt.
- On acceptance at the next edge: ptr <= (k+1) mod N, pipe_valid <= 1, pipe_din <= data of k, pipe_id <= k. With no acceptance, ptr is held, pipe_valid <= 0, and pipe_din is held.
- Tag pipeline: LAT stages of {valid, id}, fed from {pipe_valid, pipe_id} and reset to 0. The last stage is aligned with pipe_dout.
- Response at each edge: rsp_valid <= tag_valid[LAT-1], rsp_id <= tag_id[LAT-1], rsp_data <= pipe_dout. rsp_id and rsp_data are don't-care while rsp_valid=0, but they are still reset to 0.
- There is no backpressure. Responses are pulses and the receiver must sink them. Throughput is 1 accepted request per cycle sustained.
- in_flight update per edge:
  - +1 on acceptance
  - -1 when rsp_valid=1
  - both in the same cycle: unchanged
  - maximum value LAT+2, no overflow possible
- Changing req_mask affects eligibility in the same cycle. Requests already accepted always complete.
- Reset state: ptr=0, gnt=0 (combinational, because every requester is ignored during rst), pipe_valid=0, pipe_din=0, all tag stages 0, rsp_valid=0, rsp_id=0, rsp_data=0, in_flight=0.
- Reset mid-operation: all in-flight requests are dropped silently and no rsp_valid is produced for them. A request presented while rst=1 is not granted.

## Timing
- Request accepted in cycle t:
  - pipe_valid=1 in cycle t+1
  - delay output valid in cycle t+1+LAT
  - rsp_valid=1 in cycle t+2+LAT
- Total latency is LAT+2 cycles from acceptance to response.
- Grant to acceptance is 0 cycles (gnt is combinational on req, req_mask and ptr).
- Responses come out in acceptance order. Back-to-back acceptances give back-to-back responses.
- Fairness: with all N requesters continuously eligible, each is granted exactly once in every N consecutive cycles.

## Test plan
All scenarios use N=4, W=8, LAT=2.
- Single request: req=0100, req_data[2]=0x5A in cycle 0 -> gnt=0100 in cycle 0; pipe_valid=1, pipe_din=0x5A in cycle 1; rsp_valid=1, rsp_id=2, rsp_data=0x5A in cycle 4 only; in_flight=1 in cycles 1..4, 0 in cycle 5.
- Full contention: req=1111 held, data[i]=0x10+i, starting from reset -> grants 0,1,2,3,0,... each cycle; rsp_id sequence 0,1,2,3,... with rsp_data 0x10..0x13 from cycle 4; in_flight saturates at 4 and never exceeds LAT+2.
- Pointer wrap: grant 3, then req=1001 -> next grant 0, then 3.
- Mask: req=0011, req_mask=1110 -> only requester 1 is granted; requester 0 never receives gnt or rsp.
- Reset mid-flight: accept requests in cycles 0 and 1, assert rst in cycle 2 -> no rsp_valid in cycles 4..5, in_flight=0 after the reset edge, ptr=0.
- Simultaneous issue and retire: steady single-requester stream -> in_flight stays constant while rsp_valid and acceptance coincide.

Source files
------------

// File: rtl/rr_pipe_arbiter.sv
// rr_pipe_arbiter
// Round-robin arbiter that time-shares one external fixed-latency delay
// pipeline between N requesters. A tag pipeline carries the requester ID
// alongside the data, so every result returns to its owner as a one-cycle
// response pulse, LAT+2 cycles after acceptance.
module rr_pipe_arbiter #(
    parameter  int N   = 4,
    parameter  int W   = 8,
    parameter  int LAT = 2,
    localparam int IDW = $clog2(N),
    localparam int CW  = $clog2(LAT + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_data,
    input  logic [N-1:0]     req_mask,
    output logic [N-1:0]     gnt,
    output logic             pipe_valid,
    output logic [W-1:0]     pipe_din,
    input  logic [W-1:0]     pipe_dout,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic [CW-1:0]    in_flight
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic                    pipe_valid_q;
    logic [W-1:0]            pipe_din_q;
    logic [IDW-1:0]          pipe_id_q;
    logic [LAT-1:0]          tag_vld_q;
    logic [LAT-1:0][IDW-1:0] tag_id_q;
    logic                    rsp_valid_q;
    logic [IDW-1:0]          rsp_id_q;
    logic [W-1:0]            rsp_data_q;
    logic [CW-1:0]           inflight_q, inflight_d;

    // ------------------------------------------------------------------
    // Grant path
    // ------------------------------------------------------------------
    logic [N-1:0]   elig;
    logic [IDW-1:0] gnt_idx;
    logic           accept;
    logic [W-1:0]   sel_data;

    // Requests are ignored entirely while reset is held, so nothing can be
    // accepted into a pipeline that is being flushed.
    assign elig = req & req_mask & {N{~rst}};

    // Rotating-priority search: scan from ptr upward, wrapping modulo N,
    // and grant the first eligible requester.
    always_comb begin : p_grant
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int o = 0; o < N; o++) begin
            idx = int'(ptr_q) + o;
            if (idx >= N) idx = idx - N;
            if (!found && elig[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDW'(idx);
            end
        end
    end

    assign accept   = |(req & gnt);
    assign sel_data = req_data[int'(gnt_idx)*W +: W];

    // Pointer moves just past the winner so it gets lowest priority next.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (gnt_idx == IDW'(N - 1)) ptr_d = '0;
            else                        ptr_d = gnt_idx + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // ------------------------------------------------------------------
    // Launch stage: registered drive of the shared delay input
    // ------------------------------------------------------------------
    // pipe_din holds its last value when idle to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= 1'b0;
            pipe_din_q   <= '0;
            pipe_id_q    <= '0;
        end else begin
            pipe_valid_q <= accept;
            if (accept) begin
                pipe_din_q <= sel_data;
                pipe_id_q  <= gnt_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: LAT stages, last stage lines up with pipe_dout
    // ------------------------------------------------------------------
    // Shift {valid, id} in lock-step with the external delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= pipe_valid_q;
            tag_id_q[0]  <= pipe_id_q;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response stage
    // ------------------------------------------------------------------
    // Capture the delay output together with its owner tag; the pulse
    // lasts one cycle since there is no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= tag_vld_q[LAT-1];
            rsp_id_q    <= tag_id_q[LAT-1];
            rsp_data_q  <= pipe_dout;
        end
    end

    // ------------------------------------------------------------------
    // In-flight counter
    // ------------------------------------------------------------------
    // Counts from acceptance until the response pulse has been seen; peak
    // is LAT+2 so the counter never wraps.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, rsp_valid_q})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // In-flight count register.
    always_ff @(posedge clk) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pipe_valid = pipe_valid_q;
    assign pipe_din   = pipe_din_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign in_flight  = inflight_q;

endmodule
